chunked_adder_seq: RTL and testbench

//  Multi-cycle parametrised adder. Successor to the 4-bit combinational ripple adders in the labs.

---
 rtl/chunked_adder_pkg.sv | 19 +
 rtl/chunk_add.sv | 21 ++
 rtl/chunked_adder_seq.sv | 129 ++++++++++++
 tb/tb_chunked_adder_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return (chunk > 0) ? width / chunk : 1;
    endfunction

    // One spare bit so the counter can also hold NCHUNK itself.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder slice with carry-out and carry into its top bit.
module chunk_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] full;

    assign full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    assign sum   = full[W-1:0];
    assign co    = full[W];
    // The top sum bit is x ^ y ^ carry_in, so the carry into it falls out by XOR.
    assign c_msb = x[W-1] ^ y[W-1] ^ full[W-1];

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder: CHUNK bits per clock, LSB chunk first, valid/ready on both sides.
// Optional subtraction (a - b) enabled by defining SUBTRACT_EN.
module chunked_adder_seq
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NCHUNK);

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_adder_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             carry;
    logic             cout_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] b_in;
    logic             carry_in;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic             co;
    logic             c_msb;
    logic             last_chunk;

    // Subtraction is a + ~b + 1, so it only changes what gets latched at accept.
`ifdef SUBTRACT_EN
    assign b_in     = sub ? ~b : b;
    assign carry_in = sub ? 1'b1 : cin;
`else
    assign b_in     = b;
    assign carry_in = cin;
`endif

    assign a_chunk    = a_reg[int'(cnt)*CHUNK +: CHUNK];
    assign b_chunk    = b_reg[int'(cnt)*CHUNK +: CHUNK];
    assign last_chunk = (cnt == CW'(NCHUNK - 1));

    chunk_add #(.W(CHUNK)) u_chunk_add (
        .x     (a_chunk),
        .y     (b_chunk),
        .ci    (carry),
        .sum   (sum_chunk),
        .co    (co),
        .c_msb (c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry     <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b_in;
                        carry    <= carry_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    s_reg[int'(cnt)*CHUNK +: CHUNK] <= sum_chunk;
                    carry <= co;
                    cnt   <= cnt + CW'(1);
                    if (last_chunk) begin
                        cout_reg  <= co;
                        ovf_reg   <= c_msb ^ co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Return to IDLE rather than re-accepting here keeps in_ready registered.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s    = s_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Directed bench for chunked_adder_seq: three instances (CHUNK=4, 16, 1) share one stimulus.
// Define SUBTRACT_EN to also exercise the subtract path.
module tb_chunked_adder_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
`ifdef SUBTRACT_EN
    logic        sub = 1'b0;
`endif

    logic        in_ready4, out_valid4, cout4, ovf4;
    logic        in_ready16, out_valid16, cout16, ovf16;
    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [15:0] s4, s16, s1;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chunked_adder_seq #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .out_valid(out_valid4), .out_ready(out_ready), .s(s4), .cout(cout4), .ovf(ovf4)
    );

    chunked_adder_seq #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .cin(cin),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .out_valid(out_valid16), .out_ready(out_ready), .s(s16), .cout(cout16), .ovf(ovf16)
    );

    chunked_adder_seq #(.WIDTH(16), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .out_valid(out_valid1), .out_ready(out_ready), .s(s1), .cout(cout1), .ovf(ovf1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accepts one op on all instances and waits until every instance shows its result.
    task automatic sendOp(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [15:0] es, input logic ec, input logic eo);
        int lat4, lat16, lat1, n;
        @(negedge clk);
        checkOutput({tag, " in_ready4"}, 32'(in_ready4), 32'd1);
        checkOutput({tag, " in_ready1"}, 32'(in_ready1), 32'd1);
        a = ta;
        b = tb;
        cin = tcin;
`ifdef SUBTRACT_EN
        sub = tsub;
`else
        if (tsub) $display("[TB] note: %s requests subtract without SUBTRACT_EN", tag);
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~ta;
        b = ~tb;
        cin = ~tcin;
        lat4 = 999; lat16 = 999; lat1 = 999; n = 0;
        while ((lat4 == 999 || lat16 == 999 || lat1 == 999) && n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid4  && lat4  == 999) lat4  = n;
            if (out_valid16 && lat16 == 999) lat16 = n;
            if (out_valid1  && lat1  == 999) lat1  = n;
        end
        checkOutput({tag, " lat c4"},  32'(lat4),  32'd4);
        checkOutput({tag, " lat c16"}, 32'(lat16), 32'd1);
        checkOutput({tag, " lat c1"},  32'(lat1),  32'd16);
        checkOutput({tag, " s c4"},    32'(s4),    32'(es));
        checkOutput({tag, " cout c4"}, 32'(cout4), 32'(ec));
        checkOutput({tag, " ovf c4"},  32'(ovf4),  32'(eo));
        checkOutput({tag, " s c16"},   32'(s16),   32'(es));
        checkOutput({tag, " cout c16"},32'(cout16),32'(ec));
        checkOutput({tag, " ovf c16"}, 32'(ovf16), 32'(eo));
        checkOutput({tag, " s c1"},    32'(s1),    32'(es));
        checkOutput({tag, " cout c1"}, 32'(cout1), 32'(ec));
        checkOutput({tag, " ovf c1"},  32'(ovf1),  32'(eo));
    endtask

    task automatic releaseResult(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, " out_valid drop"}, 32'({out_valid4, out_valid16, out_valid1}), 32'd0);
        checkOutput({tag, " in_ready back"},  32'({in_ready4, in_ready16, in_ready1}),   32'd7);
    endtask

    task automatic applyStimulus(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tcin, input logic tsub,
                                 input logic [15:0] es, input logic ec, input logic eo);
        sendOp(tag, ta, tb, tcin, tsub, es, ec, eo);
        releaseResult(tag);
    endtask

    initial begin
        logic [16:0] full;
        logic [15:0] ra, rb;
        logic        rc, reo;
        int          rises;

        repeat (2) @(negedge clk);
        checkOutput("reset in_ready",  32'({in_ready4, in_ready16, in_ready1}),   32'd7);
        checkOutput("reset out_valid", 32'({out_valid4, out_valid16, out_valid1}), 32'd0);
        checkOutput("reset s",         32'(s4 | s16 | s1), 32'd0);
        checkOutput("reset cout/ovf",  32'({cout4, ovf4, cout1, ovf1}), 32'd0);
        rst = 1'b0;

        applyStimulus("t1 1+2",        16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        applyStimulus("t2 ffff+1",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus("t3 7fff+0+c",   16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus("t3b 8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Hold the result for six cycles while a stray request is offered.
        sendOp("t4 hold", 16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = 16'hAAAA;
            b = 16'h5555;
            in_valid = (i < 4);
            checkOutput("t4 hold s",         32'(s4),         32'h0FFF);
            checkOutput("t4 hold valid",     32'(out_valid4), 32'd1);
            checkOutput("t4 hold in_ready",  32'(in_ready4),  32'd0);
            checkOutput("t4 hold cout/ovf",  32'({cout4, ovf4}), 32'd0);
        end
        in_valid = 1'b0;
        releaseResult("t4 release");
        repeat (2) @(negedge clk);
        checkOutput("t4 stray ignored", 32'({out_valid4, in_ready4}), 32'd1);
        applyStimulus("t4 next", 16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0);

        // Reset while the CHUNK=4 instance sits at cnt=2.
        @(negedge clk);
        a = 16'h4321;
        b = 16'h1111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t5 rst in_ready",  32'(in_ready4),  32'd1);
        checkOutput("t5 rst out_valid", 32'(out_valid4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid4 || out_valid16 || out_valid1) rises++;
        end
        checkOutput("t5 no result", 32'(rises), 32'd0);
        applyStimulus("t5 1234+1111", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
        applyStimulus("t6 5-7",      16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        applyStimulus("t6 8000-1",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        applyStimulus("t6 add back", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0);
`endif

        // Random sweep, all three chunk sizes against a + b + cin.
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(1, 0));
            full = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
            reo = (ra[15] == rb[15]) && (full[15] != ra[15]);
            applyStimulus("t7 sweep", ra, rb, rc, 1'b0, full[15:0], full[16], reo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
